// File: rtl/cache_nway_pkg.sv
// Shared types and encodings for the N-way cache controller and its PLRU helper.
package cache_nway_pkg;

    typedef enum logic [1:0] {
        ST_CHECK     = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FILL      = 2'd2
    } state_e;

    // Data-array write source.
    localparam logic [1:0] WR_PMEM = 2'b00;
    localparam logic [1:0] WR_CPU  = 2'b01;
    localparam logic [1:0] WR_NONE = 2'b11;

    // Physical memory address source.
    localparam logic ADDR_REQ    = 1'b0;
    localparam logic ADDR_VICTIM = 1'b1;

endpackage

// File: rtl/cache_control_nway_plru_tree.sv
// Tree pseudo-LRU: heap-ordered nodes (children 2i+1, 2i+2), bit 0 = left, 1 = right.
// Produces the victim way for plru_in and the bits updated for an access to access_way.
module plru_tree #(
    parameter int WAYS  = 4,
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  plru_in,
    input  logic [WAY_W-1:0] access_way,
    output logic [WAY_W-1:0] victim_way,
    output logic [WAYS-2:0]  plru_out
);

    int              vic_node;
    logic            vic_bit;
    int              upd_node;
    logic            acc_bit;
    logic [WAYS-2:0] node_mask;

    // NOTE: blocking assignments are correct here -- each loop step reads the value the previous step just wrote.
    always_comb begin
        vic_node = 0;
        vic_bit  = 1'b0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            vic_bit  = 1'(plru_in >> vic_node);
            vic_node = 2 * vic_node + 1 + int'(vic_bit);
        end
        victim_way = WAY_W'(vic_node - (WAYS - 1));
    end

    // Walk the accessed way's path MSB first; each node is turned to face the other subtree.
    always_comb begin
        upd_node  = 0;
        acc_bit   = 1'b0;
        node_mask = '0;
        plru_out  = plru_in;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            acc_bit   = 1'(access_way >> (WAY_W - 1 - lvl));
            node_mask = (WAYS - 1)'(1) << upd_node;
            if (acc_bit) begin
                plru_out = plru_out & ~node_mask;
            end else begin
                plru_out = plru_out | node_mask;
            end
            upd_node = 2 * upd_node + 1 + int'(acc_bit);
        end
    end

endmodule

// File: rtl/cache_control_nway.sv
// Control FSM for a WAYS-way set-associative write-back cache with tree PLRU replacement.
// Hits respond combinationally; misses write back a dirty victim, then fill it.
module cache_control_nway
    import cache_nway_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int WAY_W = $clog2(WAYS),
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    input  logic             pmem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic [WAYS-1:0]  hit_vec,
    input  logic [WAYS-1:0]  valid_vec,
    input  logic [WAYS-1:0]  dirty_vec,
    input  logic [WAYS-2:0]  plru_in,
    output logic [WAYS-2:0]  plru_out,
    output logic             plru_load,
    output logic [WAY_W-1:0] way_sel,
    output logic [WAYS-1:0]  tag_load,
    output logic [WAYS-1:0]  valid_load,
    output logic [WAYS-1:0]  dirty_load,
    output logic             dirty_in,
    output logic [1:0]       writing,
    output logic             pmem_addr_sel,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    state_e           state_q, state_d;
    logic [WAY_W-1:0] victim_q, victim_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic [CNT_W-1:0] miss_count_q, miss_count_d;

    logic             req;
    logic             is_write;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] free_way;
    logic             any_free;
    logic [WAY_W-1:0] plru_victim;
    logic [WAYS-2:0]  plru_upd;
    logic [WAY_W-1:0] miss_victim;
    logic [WAYS-1:0]  victim_oh;

    assign req         = mem_read | mem_write;
    assign is_write    = mem_write;
    assign hit         = |hit_vec;
    assign miss_victim = any_free ? free_way : plru_victim;
    assign victim_oh   = WAYS'(1) << victim_q;
    assign hit_count   = hit_count_q;
    assign miss_count  = miss_count_q;

    plru_tree #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_plru (
        .plru_in    (plru_in),
        .access_way (hit_way),
        .victim_way (plru_victim),
        .plru_out   (plru_upd)
    );

    // hit_vec is one-hot, so OR-ing the indices of set bits yields the hit way.
    always_comb begin
        hit_way  = '0;
        free_way = '0;
        any_free = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[WAY_W'(w)]) begin
                hit_way = hit_way | WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_vec[WAY_W'(w)]) begin
                free_way = WAY_W'(w);
                any_free = 1'b1;
            end
        end
    end

    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        hit_count_d   = hit_count_q;
        miss_count_d  = miss_count_q;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        plru_out      = plru_in;
        plru_load     = 1'b0;
        way_sel       = '0;
        tag_load      = '0;
        valid_load    = '0;
        dirty_load    = '0;
        dirty_in      = 1'b0;
        writing       = WR_NONE;
        pmem_addr_sel = ADDR_REQ;

        // While reset is held nothing is driven, so an in-flight transfer cannot touch the arrays.
        if (!rst) begin
            unique case (state_q)
                ST_CHECK: begin
                    if (req && hit) begin
                        mem_resp    = 1'b1;
                        way_sel     = hit_way;
                        plru_out    = plru_upd;
                        plru_load   = 1'b1;
                        hit_count_d = hit_count_q + CNT_W'(1);
                        if (is_write) begin
                            writing    = WR_CPU;
                            dirty_load = hit_vec;
                            dirty_in   = 1'b1;
                        end
                    end else if (req) begin
                        victim_d     = miss_victim;
                        miss_count_d = miss_count_q + CNT_W'(1);
                        state_d      = dirty_vec[miss_victim] ? ST_WRITEBACK : ST_FILL;
                    end
                end

                ST_WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = ADDR_VICTIM;
                    way_sel       = victim_q;
                    if (pmem_resp) begin
                        state_d = ST_FILL;
                    end
                end

                ST_FILL: begin
                    pmem_read = 1'b1;
                    way_sel   = victim_q;
                    writing   = WR_PMEM;
                    if (pmem_resp) begin
                        tag_load   = victim_oh;
                        valid_load = victim_oh;
                        dirty_load = victim_oh;
                        dirty_in   = 1'b0;
                        state_d    = ST_CHECK;
                    end
                end

                default: begin
                    state_d = ST_CHECK;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_CHECK;
            victim_q     <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    a_hit_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(hit_vec));

    a_pmem_exclusive: assert property (@(posedge clk) disable iff (rst) !(pmem_read && pmem_write));

    a_victim_stable: assert property (@(posedge clk) disable iff (rst)
        (state_q != ST_CHECK && $past(state_q) != ST_CHECK) |-> (victim_q == $past(victim_q)));

endmodule

// File: tb/tb_cache_control_nway.sv
// Directed bench for cache_control_nway (WAYS=4): hits, clean/dirty misses, PLRU victims,
// dropped requests and reset during a fill, with a response scoreboard.
module tb_cache_control_nway;
    import cache_nway_pkg::*;

    localparam int WAYS  = 4;
    localparam int WAY_W = 2;
    localparam int CNT_W = 32;

    logic             clk;
    logic             rst;
    logic             mem_read;
    logic             mem_write;
    logic             mem_resp;
    logic             pmem_resp;
    logic             pmem_read;
    logic             pmem_write;
    logic [WAYS-1:0]  hit_vec;
    logic [WAYS-1:0]  valid_vec;
    logic [WAYS-1:0]  dirty_vec;
    logic [WAYS-2:0]  plru_in;
    logic [WAYS-2:0]  plru_out;
    logic             plru_load;
    logic [WAY_W-1:0] way_sel;
    logic [WAYS-1:0]  tag_load;
    logic [WAYS-1:0]  valid_load;
    logic [WAYS-1:0]  dirty_load;
    logic             dirty_in;
    logic [1:0]       writing;
    logic             pmem_addr_sel;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    cache_control_nway #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_resp      (mem_resp),
        .pmem_resp     (pmem_resp),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .hit_vec       (hit_vec),
        .valid_vec     (valid_vec),
        .dirty_vec     (dirty_vec),
        .plru_in       (plru_in),
        .plru_out      (plru_out),
        .plru_load     (plru_load),
        .way_sel       (way_sel),
        .tag_load      (tag_load),
        .valid_load    (valid_load),
        .dirty_load    (dirty_load),
        .dirty_in      (dirty_in),
        .writing       (writing),
        .pmem_addr_sel (pmem_addr_sel),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WAY_W-1:0] way;
        logic [1:0]       wr;
    } resp_t;

    resp_t sb[$];
    int    errors     = 0;
    int    checks     = 0;
    int    exp_hits   = 0;
    int    exp_misses = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [3:0] hit,
                         input logic [3:0] valid, input logic [3:0] dirty, input logic [2:0] plru);
        mem_read  = rd;
        mem_write = wr;
        hit_vec   = hit;
        valid_vec = valid;
        dirty_vec = dirty;
        plru_in   = plru;
    endtask

    task automatic expect_resp(input logic [WAY_W-1:0] way, input logic [1:0] wr);
        resp_t e;
        e.way = way;
        e.wr  = wr;
        sb.push_back(e);
    endtask

    // A response must be present this cycle and match the oldest queued expectation.
    task automatic take_resp(input string tag);
        resp_t e;
        check({tag, "_resp"}, 32'(mem_resp), 32'd1);
        if (mem_resp === 1'b1) begin
            check({tag, "_sb_pending"}, 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({tag, "_way"}, 32'(way_sel), 32'(e.way));
                check({tag, "_writing"}, 32'(writing), 32'(e.wr));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        pmem_resp = 1'b0;
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 3'b000);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_mem_resp", 32'(mem_resp), 32'd0);
        check("rst_pmem_read", 32'(pmem_read), 32'd0);
        check("rst_pmem_write", 32'(pmem_write), 32'd0);
        check("rst_writing", 32'(writing), 32'(WR_NONE));
        check("rst_plru_load", 32'(plru_load), 32'd0);
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);

        // Read hit on way 2 with PLRU 000: root turns left (0), node 2 turns right (1).
        tick();
        drive(1'b1, 1'b0, 4'b0100, 4'b1111, 4'b0000, 3'b000);
        expect_resp(2'd2, WR_NONE);
        exp_hits++;
        #1;
        take_resp("rd_hit");
        check("rd_hit_plru_out", 32'(plru_out), 32'b100);
        check("rd_hit_plru_load", 32'(plru_load), 32'd1);
        tick();
        drive(1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 3'b000);
        #1;
        check("rd_hit_count", hit_count, 32'(exp_hits));

        // Clean miss: way 2 is the only invalid way, so it is filled without write-back.
        tick();
        drive(1'b1, 1'b0, 4'b0000, 4'b1011, 4'b0000, 3'b000);
        expect_resp(2'd2, WR_NONE);
        exp_misses++;
        #1;
        check("cmiss_no_resp", 32'(mem_resp), 32'd0);
        check("cmiss_check_no_read", 32'(pmem_read), 32'd0);
        tick();
        check("cmiss_fill_read", 32'(pmem_read), 32'd1);
        check("cmiss_fill_no_write", 32'(pmem_write), 32'd0);
        check("cmiss_fill_way", 32'(way_sel), 32'd2);
        check("cmiss_fill_writing", 32'(writing), 32'(WR_PMEM));
        check("cmiss_count", miss_count, 32'(exp_misses));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("cmiss_fill_hold", 32'(pmem_read), 32'd1);
        end
        tick();
        pmem_resp = 1'b1;
        #1;
        check("cmiss_valid_load", 32'(valid_load), 32'b0100);
        check("cmiss_tag_load", 32'(tag_load), 32'b0100);
        check("cmiss_dirty_load", 32'(dirty_load), 32'b0100);
        check("cmiss_dirty_in", 32'(dirty_in), 32'd0);
        check("cmiss_fill_no_plru", 32'(plru_load), 32'd0);
        tick();
        pmem_resp = 1'b0;
        drive(1'b1, 1'b0, 4'b0100, 4'b1111, 4'b0000, 3'b000);
        exp_hits++;
        #1;
        take_resp("cmiss_rehit");
        check("cmiss_rehit_no_read", 32'(pmem_read), 32'd0);
        tick();
        drive(1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 3'b000);
        #1;
        check("cmiss_hit_count", hit_count, 32'(exp_hits));

        // A stray pmem_resp while idle in CHECK changes nothing.
        tick();
        pmem_resp = 1'b1;
        #1;
        check("stray_resp_no_install", 32'(valid_load), 32'd0);
        tick();
        pmem_resp = 1'b0;
        #1;
        check("stray_resp_no_read", 32'(pmem_read), 32'd0);
        check("stray_resp_no_write", 32'(pmem_write), 32'd0);

        // Dirty miss, all valid, PLRU 011: root 1 -> node 2, node 2 = 0 -> way 2 (dirty).
        tick();
        drive(1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0100, 3'b011);
        expect_resp(2'd2, WR_NONE);
        exp_misses++;
        #1;
        check("dmiss_no_resp", 32'(mem_resp), 32'd0);
        tick();
        check("dmiss_wb_write", 32'(pmem_write), 32'd1);
        check("dmiss_wb_no_read", 32'(pmem_read), 32'd0);
        check("dmiss_wb_addr_sel", 32'(pmem_addr_sel), 32'(ADDR_VICTIM));
        check("dmiss_wb_way", 32'(way_sel), 32'd2);
        check("dmiss_wb_writing", 32'(writing), 32'(WR_NONE));
        tick();
        check("dmiss_wb_hold", 32'(pmem_write), 32'd1);
        tick();
        pmem_resp = 1'b1;
        #1;
        check("dmiss_wb_no_install", 32'(valid_load), 32'd0);
        tick();
        pmem_resp = 1'b0;
        #1;
        check("dmiss_fill_read", 32'(pmem_read), 32'd1);
        check("dmiss_fill_no_write", 32'(pmem_write), 32'd0);
        check("dmiss_fill_addr_sel", 32'(pmem_addr_sel), 32'(ADDR_REQ));
        check("dmiss_fill_way", 32'(way_sel), 32'd2);
        check("dmiss_count", miss_count, 32'(exp_misses));
        tick();
        pmem_resp = 1'b1;
        #1;
        check("dmiss_valid_load", 32'(valid_load), 32'b0100);
        check("dmiss_dirty_load", 32'(dirty_load), 32'b0100);
        check("dmiss_dirty_in", 32'(dirty_in), 32'd0);
        tick();
        pmem_resp = 1'b0;
        drive(1'b1, 1'b0, 4'b0100, 4'b1111, 4'b0000, 3'b011);
        exp_hits++;
        #1;
        take_resp("dmiss_rehit");
        check("dmiss_rehit_plru_out", 32'(plru_out), 32'b110);
        tick();
        drive(1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 3'b000);
        #1;
        check("dmiss_hit_count", hit_count, 32'(exp_hits));

        // Write hit on way 1: root turns right (1), node 1 turns left (0).
        tick();
        drive(1'b0, 1'b1, 4'b0010, 4'b1111, 4'b0000, 3'b000);
        expect_resp(2'd1, WR_CPU);
        exp_hits++;
        #1;
        take_resp("wr_hit");
        check("wr_hit_dirty_load", 32'(dirty_load), 32'b0010);
        check("wr_hit_dirty_in", 32'(dirty_in), 32'd1);
        check("wr_hit_plru_out", 32'(plru_out), 32'b001);

        // Read and write together on a hit to way 3 behave as a write.
        tick();
        drive(1'b1, 1'b1, 4'b1000, 4'b1111, 4'b0000, 3'b000);
        expect_resp(2'd3, WR_CPU);
        exp_hits++;
        #1;
        take_resp("rw_hit");
        check("rw_hit_dirty_load", 32'(dirty_load), 32'b1000);
        check("rw_hit_plru_out", 32'(plru_out), 32'b000);
        tick();
        drive(1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 3'b000);
        #1;
        check("rw_hit_count", hit_count, 32'(exp_hits));

        // Miss with PLRU 111 picks way 3; the request is dropped mid-fill but the line still installs.
        tick();
        drive(1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0000, 3'b111);
        exp_misses++;
        tick();
        mem_read = 1'b0;
        #1;
        check("drop_fill_read", 32'(pmem_read), 32'd1);
        check("drop_fill_way", 32'(way_sel), 32'd3);
        tick();
        pmem_resp = 1'b1;
        #1;
        check("drop_valid_load", 32'(valid_load), 32'b1000);
        tick();
        pmem_resp = 1'b0;
        #1;
        check("drop_no_resp", 32'(mem_resp), 32'd0);
        check("drop_back_to_check", 32'(pmem_read), 32'd0);
        check("drop_miss_count", miss_count, 32'(exp_misses));

        // Reset in the third FILL cycle: no install that cycle, idle afterwards, counters cleared.
        tick();
        drive(1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0000, 3'b000);
        tick();
        check("rstfill_way", 32'(way_sel), 32'd0);
        check("rstfill_read", 32'(pmem_read), 32'd1);
        tick();
        tick();
        rst       = 1'b1;
        pmem_resp = 1'b1;
        #1;
        check("rstfill_no_valid_load", 32'(valid_load), 32'd0);
        check("rstfill_no_tag_load", 32'(tag_load), 32'd0);
        check("rstfill_read_off", 32'(pmem_read), 32'd0);
        tick();
        rst        = 1'b0;
        pmem_resp  = 1'b0;
        mem_read   = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        #1;
        check("postrst_read", 32'(pmem_read), 32'd0);
        check("postrst_write", 32'(pmem_write), 32'd0);
        check("postrst_valid_load", 32'(valid_load), 32'd0);
        check("postrst_hit_count", hit_count, 32'(exp_hits));
        check("postrst_miss_count", miss_count, 32'(exp_misses));

        // Read hit on way 0 after reset: both nodes on its path turn right.
        tick();
        drive(1'b1, 1'b0, 4'b0001, 4'b1111, 4'b0000, 3'b000);
        expect_resp(2'd0, WR_NONE);
        exp_hits++;
        #1;
        take_resp("postrst_hit");
        check("postrst_hit_plru_out", 32'(plru_out), 32'b011);
        tick();
        drive(1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 3'b000);
        #1;
        check("postrst_hit_count_after", hit_count, 32'(exp_hits));

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
